// File: rtl/cacheline_adapter.sv
// Cache line adapter: presents a 256-bit line read/write port to the cache and
// moves each line as a 4-beat burst of 64-bit words on the memory side.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a cache request; read takes priority over write
// RD      | read burst in flight, each resp_i beat lands in line_o
// WR      | write burst in flight, burst_o shows the beat at the counter
// DONE    | one-cycle completion pulse to the cache, then back to IDLE
module cacheline_adapter #(
  parameter int S_LINE   = 256,
  parameter int S_BURST  = 64,
  parameter int N_BEATS  = S_LINE / S_BURST,
  parameter int S_OFFSET = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  input  logic [S_LINE-1:0]  line_i,
  output logic [S_LINE-1:0]  line_o,
  output logic               resp_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  output logic [S_BURST-1:0] burst_o,
  input  logic [S_BURST-1:0] burst_i,
  input  logic               resp_i
);

  localparam int CW = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [31:0]       r_addr_buf;
  logic [S_LINE-1:0] r_line_buf;
  logic [S_LINE-1:0] r_line;
  logic              w_last;
  logic              w_unused_addr_lsb;

  assign w_last = (r_cnt == CW'(N_BEATS - 1));

  // The byte offset within the line is dropped on the memory side.
  assign w_unused_addr_lsb = ^r_addr_buf[S_OFFSET-1:0];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a burst ends on the beat accepted at the last count.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (read_i) begin
          w_state_nxt = ST_RD;
        end else if (write_i) begin
          w_state_nxt = ST_WR;
        end
      end
      ST_RD: begin
        if (resp_i && w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_WR: begin
        if (resp_i && w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Request capture, read-beat assembly and the shared beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_addr_buf <= '0;
      r_line_buf <= '0;
      r_line     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (read_i) begin
            r_addr_buf <= address_i;
          end else if (write_i) begin
            r_addr_buf <= address_i;
            r_line_buf <= line_i;
          end
        end
        ST_RD: begin
          if (resp_i) begin
            r_line[r_cnt*S_BURST +: S_BURST] <= burst_i;
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_WR: begin
          if (resp_i) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs decode directly from state so beat 0 is on burst_o in the first WR cycle.
  always_comb begin
    read_o    = (r_state == ST_RD);
    write_o   = (r_state == ST_WR);
    resp_o    = (r_state == ST_DONE);
    line_o    = r_line;
    address_o = {r_addr_buf[31:S_OFFSET], {S_OFFSET{1'b0}}};
    burst_o   = '0;
    if (r_state == ST_WR) begin
      burst_o = r_line_buf[r_cnt*S_BURST +: S_BURST];
    end
  end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed bench for cacheline_adapter: reads, writes, stalls, back-to-back
// transactions, mid-burst reset and request priority.
module tb_cacheline_adapter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic         resp_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic [63:0]  burst_o;
  logic [63:0]  burst_i;
  logic         resp_i;

  int n_checks = 0;
  int n_fail   = 0;

  logic [255:0] l1, l3, l4, l5, lw, lw2;
  logic [63:0]  exp_w [4];
  logic         pat [7];

  always #5 clk = ~clk;

  cacheline_adapter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .line_i    (line_i),
    .line_o    (line_o),
    .resp_o    (resp_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .burst_o   (burst_o),
    .burst_i   (burst_i),
    .resp_i    (resp_i)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full read with no memory stalls; data must come back as the given line.
  task automatic run_read(input logic [31:0] addr, input logic [31:0] exp_addr,
                          input logic [255:0] line, input string tag);
    read_i    = 1'b1;
    address_i = addr;
    tick();
    for (int i = 0; i < 4; i++) begin
      check({tag, "_read_o"}, 256'(read_o), 256'(1));
      check({tag, "_write_o"}, 256'(write_o), 256'(0));
      check({tag, "_resp_o"}, 256'(resp_o), 256'(0));
      check({tag, "_addr"}, 256'(address_o), 256'(exp_addr));
      resp_i  = 1'b1;
      burst_i = line[i*64 +: 64];
      tick();
    end
    resp_i  = 1'b0;
    check({tag, "_done_resp"}, 256'(resp_o), 256'(1));
    check({tag, "_done_read"}, 256'(read_o), 256'(0));
    check({tag, "_line"}, line_o, line);
    read_i  = 1'b0;
    write_i = 1'b0;
    tick();
    check({tag, "_idle_resp"}, 256'(resp_o), 256'(0));
    check({tag, "_idle_read"}, 256'(read_o), 256'(0));
  endtask

  initial begin
    l1  = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
    l3  = {64'hD4D4D4D4D4D4D4D4, 64'hC3C3C3C3C3C3C3C3, 64'hB2B2B2B2B2B2B2B2, 64'hA1A1A1A1A1A1A1A1};
    l4  = {64'h0404040404040404, 64'h0303030303030303, 64'h0202020202020202, 64'h0101010101010101};
    l5  = {64'h5555000055550004, 64'h5555000055550003, 64'h5555000055550002, 64'h5555000055550001};
    lw  = 256'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0;
    lw2 = 256'hcafe0000cafe0003_cafe0000cafe0002_cafe0000cafe0001_cafe0000cafe0000;
    exp_w[0] = 64'h8796a5b4c3d2e1f0;
    exp_w[1] = 64'h0f1e2d3c4b5a6978;
    exp_w[2] = 64'hfedcba9876543210;
    exp_w[3] = 64'h0123456789abcdef;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    pat[4] = 1'b1; pat[5] = 1'b0; pat[6] = 1'b1;

    rst_n     = 1'b0;
    address_i = '0;
    read_i    = 1'b0;
    write_i   = 1'b0;
    line_i    = '0;
    burst_i   = '0;
    resp_i    = 1'b0;
    #12;
    check("rst_line", line_o, 256'(0));
    check("rst_addr", 256'(address_o), 256'(0));
    check("rst_burst", 256'(burst_o), 256'(0));
    check("rst_read", 256'(read_o), 256'(0));
    check("rst_write", 256'(write_o), 256'(0));
    check("rst_resp", 256'(resp_o), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Plain read with unaligned address.
    run_read(32'h1234_567F, 32'h1234_5660, l1, "rd");
    check("idle_addr_hold", 256'(address_o), 256'(32'h1234_5660));

    // Write; request inputs change after acceptance and must not matter.
    line_i    = lw;
    address_i = 32'h0000_0040;
    write_i   = 1'b1;
    tick();
    line_i    = '1;
    address_i = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      check("wr_write_o", 256'(write_o), 256'(1));
      check("wr_read_o", 256'(read_o), 256'(0));
      check("wr_addr", 256'(address_o), 256'(32'h0000_0040));
      check("wr_burst", 256'(burst_o), 256'(exp_w[i]));
      check("wr_resp", 256'(resp_o), 256'(0));
      resp_i = 1'b1;
      tick();
    end
    check("wr_done_resp", 256'(resp_o), 256'(1));
    check("wr_done_write", 256'(write_o), 256'(0));
    check("wr_line_kept", line_o, l1);
    write_i = 1'b0;
    tick();
    check("wr_idle_resp", 256'(resp_o), 256'(0));
    check("wr_idle_write", 256'(write_o), 256'(0));
    check("wr_idle_read", 256'(read_o), 256'(0));
    resp_i = 1'b0;

    // Stalled read followed by a back-to-back write.
    read_i    = 1'b1;
    address_i = 32'h0000_1000;
    tick();
    begin
      int b;
      b = 0;
      for (int c = 0; c < 7; c++) begin
        check("st_read_o", 256'(read_o), 256'(1));
        check("st_resp", 256'(resp_o), 256'(0));
        resp_i = pat[c];
        if (pat[c]) begin
          burst_i = l3[b*64 +: 64];
          b++;
        end else begin
          burst_i = 64'hDEADBEEFDEADBEEF;
        end
        tick();
      end
    end
    resp_i = 1'b0;
    check("st_done_resp", 256'(resp_o), 256'(1));
    check("st_done_read", 256'(read_o), 256'(0));
    check("st_line", line_o, l3);
    read_i = 1'b0;
    tick();
    check("st_idle_resp", 256'(resp_o), 256'(0));
    write_i   = 1'b1;
    line_i    = lw2;
    address_i = 32'h0000_0080;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("b2b_write_o", 256'(write_o), 256'(1));
      check("b2b_burst", 256'(burst_o), 256'(lw2[i*64 +: 64]));
      check("b2b_line_kept", line_o, l3);
      resp_i = 1'b1;
      tick();
    end
    resp_i = 1'b0;
    check("b2b_done_resp", 256'(resp_o), 256'(1));
    check("b2b_addr", 256'(address_o), 256'(32'h0000_0080));
    write_i = 1'b0;
    tick();

    // Reset in the middle of a read, after two beats.
    read_i    = 1'b1;
    address_i = 32'h0000_2000;
    tick();
    for (int i = 0; i < 2; i++) begin
      resp_i  = 1'b1;
      burst_i = 64'h7777777777777777;
      tick();
    end
    resp_i = 1'b0;
    read_i = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("mrst_read", 256'(read_o), 256'(0));
    check("mrst_resp", 256'(resp_o), 256'(0));
    check("mrst_line", line_o, 256'(0));
    check("mrst_addr", 256'(address_o), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run_read(32'h0000_2000, 32'h0000_2000, l4, "mrst_rd");

    // Simultaneous read and write: read wins.
    write_i = 1'b1;
    run_read(32'h0000_3FFF, 32'h0000_3FE0, l5, "both");

    // resp_i in IDLE with no request changes nothing.
    resp_i  = 1'b1;
    burst_i = 64'h9999999999999999;
    tick();
    tick();
    check("idle_resp_i_resp", 256'(resp_o), 256'(0));
    check("idle_resp_i_read", 256'(read_o), 256'(0));
    check("idle_resp_i_write", 256'(write_o), 256'(0));
    check("idle_resp_i_line", line_o, l5);
    resp_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cacheline_adapter.md
Name: cacheline_adapter

Overview:
- Bridges the cache's 256-bit line interface to the 64-bit burst memory.
- Acts as responder to the cache's line read/write requests and as initiator of 4-beat bursts on the memory side.
- Sits between the cache datapath/control and main memory; performs line assembly on reads and line serialization on writes.

Parameters:
s_line, 256, cache line width in bits
s_burst, 64, memory beat width in bits
n_beats, s_line/s_burst (4), beats per line; must be a power of two
s_offset, 5, byte-offset bits zeroed in the memory address

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
address_i  input  32  cache-side line address
read_i  input  1  cache line read request, level, held until resp_o
write_i  input  1  cache line write request, level, held until resp_o
line_i  input  s_line  line data to write
line_o  output  s_line  assembled read line
resp_o  output  1  one-cycle completion pulse to cache
address_o  output  32  memory address, line aligned
read_o  output  1  memory burst read request
write_o  output  1  memory burst write request
burst_o  output  s_burst  write beat data
burst_i  input  s_burst  read beat data
resp_i  input  1  memory beat valid/accept, one per beat

Behaviour:
- Reset (rst_n low, async): state IDLE; beat counter 0; line_o, address_o, burst_o all 0; read_o, write_o, resp_o all 0; internal line and address buffers cleared.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - read_i=1 -> latch address_i into address buffer, go RD.
  - Otherwise write_i=1 -> latch address_i and line_i, go WR.
  - Both asserted is illegal; read wins.
  - resp_i is ignored in IDLE.
- address_o = {addr_buf[31:s_offset], s_offset'b0}. Valid and stable throughout RD/WR; holds its last value otherwise.
- RD:
  - read_o=1.
  - Each cycle with resp_i=1: capture burst_i into line_o[s_burst*cnt +: s_burst], then cnt++.
  - Cycles with resp_i=0 are stalls: no capture, no count change. Gaps between beats are tolerated.
  - When the beat at cnt=n_beats-1 is captured: cnt wraps to 0, go DONE.
- WR:
  - write_o=1.
  - burst_o = line_buf[s_burst*cnt +: s_burst], combinational from cnt, so beat 0 is present in the first WR cycle.
  - Each resp_i=1 cycle: cnt++.
  - On the last beat: cnt wraps to 0, go DONE.
- DONE:
  - resp_o=1 for exactly this cycle; read_o=write_o=0.
  - line_o is valid; requests are ignored.
  - Unconditionally go IDLE.
- Latency, no memory stalls: request sampled at edge 0; read_o/write_o high for cycles 1..4; resp_o in cycle 5.
- Cache must drop its request the cycle after resp_o. A request still high in IDLE starts a new transaction.
- line_o holds its value until overwritten by a later read's beats. Writes never modify line_o.
- line_i and address_i changes after acceptance have no effect on the transaction in flight.
- resp_i high in DONE is ignored.
- Reset asserted mid-burst: immediate return to IDLE, outputs zeroed, partial line_o discarded (zeroed).
- Counter width is log2(n_beats); wrap is natural modulo arithmetic.

Test Plan:
- Read, no stalls: read_i=1, address_i=0x1234_567F; memory returns beats 0x1111..., 0x2222..., 0x3333..., 0x4444... on 4 consecutive resp_i cycles -> address_o=0x1234_5660; read_o high 4 cycles; resp_o pulse in cycle 5; line_o={0x4444..,0x3333..,0x2222..,0x1111..}.
- Write: line_i=256'h0123...CDEF, address_i=0x0000_0040 -> write_o high; burst_o presents line_i[63:0], [127:64], [191:128], [255:192] on successive resp_i cycles; address_o=0x0000_0040; single resp_o pulse after 4th beat.
- Stalled read: resp_i pattern 1,0,0,1,1,0,1 -> exactly 4 beats captured in order; read_o stays high across gaps; resp_o one cycle after 7th cycle; no extra pulses.
- Back-to-back: read completes, read_i drops, write_i asserted the cycle after resp_o -> write starts from IDLE with cnt=0 and burst_o=beat 0; line_o retains the read data.
- Reset mid-operation: rst_n low after beat 2 of a read -> read_o, resp_o, line_o=0 immediately; after release, a new read returns a correct full line.
- Simultaneous read_i & write_i in IDLE -> read performed (read_o=1, write_o=0); resp_i in IDLE with no request -> no state change, no resp_o.
